// File: rtl/dgate_mac_seq.sv
// dgate_mac_seq
//   Back-propagation MAC stage that sits after the LSTM delta unit. One
//   timestep's N_IN gate deltas are buffered. Then, for each output j, the stage
//   streams weights w[k*N_OUT+j] for k=0..N_IN-1 and accumulates the
//   fixed-point products. Each saturated result is written out with its
//   address j.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous reset, active low
//   i_start      pulse that begins a timestep (taken in IDLE only)
//   i_dgate_vld  i_dgate valid (taken in LOAD only)
//   i_dgate      gate delta, arrives in order k=0..N_IN-1
//   o_w_addr     weight memory read address (holds between issues)
//   i_w          weight read data, one cycle after o_w_addr
//   o_wr         result write strobe
//   o_wr_addr    result address j
//   o_wr_data    saturated result
//   o_busy       high in every state except IDLE
//   o_done       one-cycle pulse after the last write
//   o_dbg_state  current FSM state (debug visibility)
//
// Handshake: i_dgate is consumed on every clock edge at which the FSM is in
// LOAD and i_dgate_vld is high. There is no backpressure, so the producer
// never waits. o_wr is a one-cycle strobe with no ready signal. o_wr_addr and
// o_wr_data are only meaningful while o_wr is high, and read 0 otherwise.
module dgate_mac_seq #(
  parameter int WIDTH = 24,
  parameter int FRAC  = 20,
  parameter int N_IN  = 32,
  parameter int N_OUT = 8,
  parameter int GUARD = 8,
  parameter int AW    = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_dgate_vld,
  input  logic [WIDTH-1:0] i_dgate,
  output logic [AW-1:0]    o_w_addr,
  input  logic [WIDTH-1:0] i_w,
  output logic             o_wr,
  output logic [AW-1:0]    o_wr_addr,
  output logic [WIDTH-1:0] o_wr_data,
  output logic             o_busy,
  output logic             o_done,
  output logic [2:0]       o_dbg_state
);

  localparam int ACCW = WIDTH + GUARD;
  localparam int KW   = (N_IN  > 1) ? $clog2(N_IN)  : 1;
  localparam int JW   = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  localparam logic [KW-1:0] K_LAST = KW'(N_IN - 1);
  localparam logic [JW-1:0] J_LAST = JW'(N_OUT - 1);
  localparam logic [AW-1:0] W_STEP = AW'(N_OUT);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_MAC   = 3'd2,
    S_DRAIN = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [KW-1:0]           r_k;
  logic [KW-1:0]           r_kp;     // k of the issue made last cycle
  logic                    r_issue;  // a weight read was issued last cycle
  logic [JW-1:0]           r_j;
  logic [AW-1:0]           r_w_addr;
  logic signed [ACCW-1:0]  r_acc;
  logic [WIDTH-1:0]        r_buf [N_IN];

  logic                    w_k_last;
  logic                    w_j_last;
  logic [JW-1:0]           w_j_inc;
  logic signed [WIDTH-1:0]   w_dg;
  logic signed [WIDTH-1:0]   w_wt;
  logic signed [2*WIDTH-1:0] w_prod;
  logic signed [ACCW-1:0]    w_term;
  logic                      w_ovf;
  logic [WIDTH-1:0]          w_sat;

  assign w_k_last = (r_k == K_LAST);
  assign w_j_last = (r_j == J_LAST);
  assign w_j_inc  = r_j + JW'(1);

  // Product of the buffered delta and the weight returned for last cycle's
  // issue. The arithmetic shift rounds toward minus infinity.
  assign w_dg   = r_buf[r_kp];
  assign w_wt   = i_w;
  assign w_prod = w_dg * w_wt;
  assign w_term = ACCW'(w_prod >>> FRAC);

  // Overflow when the guard bits plus the result sign bit are not all equal.
  assign w_ovf = (r_acc[ACCW-1:WIDTH-1] != {(GUARD+1){r_acc[ACCW-1]}});
  assign w_sat = !w_ovf        ? r_acc[WIDTH-1:0] :
                 r_acc[ACCW-1] ? {1'b1, {(WIDTH-1){1'b0}}} :
                                 {1'b0, {(WIDTH-1){1'b1}}};

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // FSM next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_next = S_LOAD;
      S_LOAD:  if (i_dgate_vld && w_k_last) w_next = S_MAC;
      S_MAC:   if (w_k_last) w_next = S_DRAIN;
      S_DRAIN: w_next = S_WRITE;
      S_WRITE: w_next = w_j_last ? S_DONE : S_MAC;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: buffer, counters, address generator and accumulator
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_k      <= '0;
      r_kp     <= '0;
      r_issue  <= 1'b0;
      r_j      <= '0;
      r_w_addr <= '0;
      r_acc    <= '0;
      for (int i = 0; i < N_IN; i++) r_buf[i] <= '0;
    end else begin
      r_issue <= (r_state == S_MAC);
      r_kp    <= r_k;
      // The first product of each output replaces the stale sum.
      if (r_issue) r_acc <= (r_kp == '0) ? w_term : r_acc + w_term;
      case (r_state)
        S_LOAD: begin
          if (i_dgate_vld) begin
            r_buf[r_k] <= i_dgate;
            if (w_k_last) begin
              r_k      <= '0;
              r_j      <= '0;
              r_w_addr <= '0;
            end else begin
              r_k <= r_k + KW'(1);
            end
          end
        end
        S_MAC: begin
          // Address walks k*N_OUT+j by repeated addition of N_OUT.
          if (w_k_last) begin
            r_k <= '0;
          end else begin
            r_k      <= r_k + KW'(1);
            r_w_addr <= r_w_addr + W_STEP;
          end
        end
        S_WRITE: begin
          if (!w_j_last) begin
            r_j      <= w_j_inc;
            r_w_addr <= AW'(w_j_inc);
          end
        end
        default: ;
      endcase
    end
  end

  assign o_w_addr    = r_w_addr;
  assign o_wr        = (r_state == S_WRITE);
  assign o_wr_addr   = (r_state == S_WRITE) ? AW'(r_j) : '0;
  assign o_wr_data   = (r_state == S_WRITE) ? w_sat : '0;
  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = (r_state == S_DONE);
  assign o_dbg_state = r_state;

endmodule
